// File: rtl/gus16_mem_sequencer.sv
// gus16_mem_sequencer
//
// Shares one external memory port between the CPU and the debug/loader
// requester. Each 16-bit access goes out on the 8-bit uio bus as four byte
// phases: address-high, address-low, data-high, data-low. Each phase has its
// own strobe. The two data phases can be stretched by WAIT_STATES cycles.
//
// Parameters
//   WAIT_STATES  extra cycles in each data phase (0..7)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        when low, no new grant is made
//   c_req/c_we/c_addr/c_wdata  CPU request channel, c_ack completion pulse
//   d_req/d_we/d_addr/d_wdata  debug/loader request channel, d_ack pulse
//   rdata                      last read word (valid from the ack cycle on)
//   bus_out/bus_in/bus_oe      uio pin byte out / in / output enable
//   bus_alh/bus_all            address-high / address-low latch strobes
//   bus_rd/bus_wr              read / write strobes during the data phases
module gus16_mem_sequencer #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic        c_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] rdata,
    output logic [7:0]  bus_out,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_oe,
    output logic        bus_alh,
    output logic        bus_all,
    output logic        bus_rd,
    output logic        bus_wr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADH,
        S_ADL,
        S_DH,
        S_DL,
        S_ACK
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

    state_t      state_reg, state_next;
    logic        gnt_dbg_reg, gnt_dbg_next;    // 1 = current access belongs to debug port
    logic        last_dbg_reg, last_dbg_next;  // 1 = debug port was granted last
    logic        we_reg, we_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic [2:0]  wait_reg, wait_next;
    logic [15:0] rdata_reg;
    logic        phase_done;
    logic        pick_dbg;

    // A data phase ends in the cycle when the wait counter reaches its limit.
    assign phase_done = (wait_reg == WAIT_LAST);

    // Round robin on a tie: the debug port wins only if the CPU went last.
    assign pick_dbg = d_req && (!c_req || !last_dbg_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            gnt_dbg_reg  <= 1'b0;
            last_dbg_reg <= 1'b1;
            we_reg       <= 1'b0;
            addr_reg     <= 16'h0000;
            wdata_reg    <= 16'h0000;
            wait_reg     <= 3'd0;
        end else begin
            state_reg    <= state_next;
            gnt_dbg_reg  <= gnt_dbg_next;
            last_dbg_reg <= last_dbg_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            wait_reg     <= wait_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_dbg_next  = gnt_dbg_reg;
        last_dbg_next = last_dbg_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wait_next     = wait_reg;
        case (state_reg)
            S_IDLE: begin
                if (ena && (c_req || d_req)) begin
                    gnt_dbg_next  = pick_dbg;
                    last_dbg_next = pick_dbg;
                    we_next       = pick_dbg ? d_we    : c_we;
                    addr_next     = pick_dbg ? d_addr  : c_addr;
                    wdata_next    = pick_dbg ? d_wdata : c_wdata;
                    state_next    = S_ADH;
                end
            end
            S_ADH: state_next = S_ADL;
            S_ADL: begin
                wait_next  = 3'd0;
                state_next = S_DH;
            end
            S_DH: begin
                if (phase_done) begin
                    wait_next  = 3'd0;
                    state_next = S_DL;
                end else begin
                    wait_next = wait_reg + 3'd1;
                end
            end
            S_DL: begin
                if (phase_done) begin
                    wait_next  = 3'd0;
                    state_next = S_ACK;
                end else begin
                    wait_next = wait_reg + 3'd1;
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Read bytes are captured only on the edge that closes their data phase.
    // Byte 1 (high) closes in DH, byte 0 (low) closes in DL.
    // Writes and idle cycles leave rdata alone.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rbyte
            localparam state_t CAP_STATE = (gi == 1) ? S_DH : S_DL;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi*8 +: 8] <= 8'h00;
                end else if (state_reg == CAP_STATE && !we_reg && phase_done) begin
                    rdata_reg[gi*8 +: 8] <= bus_in;
                end
            end
        end
    endgenerate

    assign rdata = rdata_reg;

    // Pin outputs decode straight from the state. Because of that, an
    // asynchronous reset drops every strobe at once.
    always_comb begin
        bus_out = 8'h00;
        bus_oe  = 8'h00;
        bus_alh = 1'b0;
        bus_all = 1'b0;
        bus_rd  = 1'b0;
        bus_wr  = 1'b0;
        c_ack   = 1'b0;
        d_ack   = 1'b0;
        case (state_reg)
            S_ADH: begin
                bus_out = addr_reg[15:8];
                bus_oe  = 8'hFF;
                bus_alh = 1'b1;
            end
            S_ADL: begin
                bus_out = addr_reg[7:0];
                bus_oe  = 8'hFF;
                bus_all = 1'b1;
            end
            S_DH: begin
                if (we_reg) begin
                    bus_out = wdata_reg[15:8];
                    bus_oe  = 8'hFF;
                    bus_wr  = 1'b1;
                end else begin
                    bus_rd = 1'b1;
                end
            end
            S_DL: begin
                if (we_reg) begin
                    bus_out = wdata_reg[7:0];
                    bus_oe  = 8'hFF;
                    bus_wr  = 1'b1;
                end else begin
                    bus_rd = 1'b1;
                end
            end
            S_ACK: begin
                c_ack = !gnt_dbg_reg;
                d_ack = gnt_dbg_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/gus16_mem_sequencer.md
Name: gus16_mem_sequencer

Overview:
- Sequences 16-bit memory transactions for the gus16 core over the 8-bit bidirectional uio pin bus.
- Arbitrates one shared external memory port between two requesters: CPU (port c_) and debug/loader (port d_).
- Serialises each access as address-high, address-low, data-high, data-low byte phases with external strobes.
- Sits between the core/debug logic and the top-level uio_out/uio_in/uio_oe pins.

Parameters:
- WAIT_STATES, 0, extra clock cycles inserted in each data phase (DH, DL) before the byte is sampled or the write strobe ends; range 0..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when low no new grants are made
- c_req  in  1  CPU request; held high until c_ack
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  16  CPU word address
- c_wdata  in  16  CPU write data
- c_ack  out  1  one-cycle completion pulse to CPU
- d_req, d_we, d_addr[16], d_wdata[16], d_ack  same as c_ port, for debug/loader
- rdata  out  16  read data, valid in the ack cycle and held until the next read completes
- bus_out  out  8  byte driven onto the uio pins
- bus_in  in  8  byte sampled from the uio pins
- bus_oe  out  8  pin output enable, all-ones or all-zeros
- bus_alh  out  1  address-high latch strobe
- bus_all  out  1  address-low latch strobe
- bus_rd  out  1  read strobe (data phases)
- bus_wr  out  1  write strobe (data phases)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, all outputs 0, rdata=0, wait counter=0.
  - last-grant register = DBG, so the CPU wins the first tie.
  - Reset mid-transaction aborts it: no ack, strobes drop immediately.
- States: IDLE, ADH, ADL, DH, DL, ACK.
- IDLE:
  - If ena=1 and any req is high, grant, latch the requester id, we, addr and wdata, and go to ADH.
  - Otherwise stay in IDLE.
  - Tie (both req high): grant the requester not granted last (round robin). Single request: grant it.
  - The last-grant register updates on grant.
- ADH (1 cycle): bus_out=addr[15:8], bus_oe=FF, bus_alh=1.
- ADL (1 cycle): bus_out=addr[7:0], bus_oe=FF, bus_all=1.
- DH (1+WAIT_STATES cycles):
  - Write: bus_out=wdata[15:8], bus_oe=FF, bus_wr=1.
  - Read: bus_oe=00, bus_out=00, bus_rd=1; bus_in is captured into rdata[15:8] on the clock edge that ends the last cycle of the phase.
- DL (1+WAIT_STATES cycles): same as DH using byte [7:0].
- ACK (1 cycle): the granted requester's ack=1, all strobes 0, bus_oe=00; then go to IDLE.
- Timing:
  - Grant at edge t means ADH occupies cycle t+1.
  - Ack is high in cycle t+5+2*WAIT_STATES.
  - With WAIT_STATES=0: ADH, ADL, DH, DL, ACK occupy cycles t+1..t+5.
- Gaps and holds:
  - IDLE is always occupied for at least one cycle between transactions; there is no grant in ACK.
  - Outside ADH/ADL/write-data phases: bus_oe=00 and bus_out=00.
  - rdata is not modified by writes or by idle cycles.
- Strobes are mutually exclusive; at most one of alh/all/rd/wr is high in any cycle.
- Latched values:
  - ena dropping mid-transaction does not stop it; the transaction completes and acks.
  - Requester address/data changes after grant are ignored (values are latched).
- A requester dropping req before ack is a protocol violation. The transaction still completes and the ack is still pulsed.

Test Plan:
- Reset, then CPU read of 0x1234 with WAIT_STATES=0 and bus_in=0xAB in DH, 0xCD in DL:
  - bus_out sequence 0x12 (alh), 0x34 (all), then rd for 2 cycles.
  - c_ack in 5th cycle after grant; rdata=0xABCD.
- Debug write of 0xBEEF to 0x00F0: bus_out 0x00, 0xF0, 0xBE, 0xEF with bus_oe=FF and wr high on the last two; d_ack pulses once; rdata unchanged.
- c_req and d_req asserted on the same cycle after reset, held for two transactions each: grant order CPU, DBG, CPU, DBG; acks never overlap; one IDLE cycle between transactions.
- WAIT_STATES=2, CPU read: each data phase lasts 3 cycles; rdata bytes are sampled only at the end of each phase (bus_in changes mid-phase are ignored); ack at cycle 9 after grant.
- rst_n pulsed low during DH of a write: all strobes and bus_oe go 0 asynchronously, no ack, state IDLE; the next request completes normally.
- ena=0 with c_req high: no grant and bus idle. Raise ena: transaction starts next cycle. Drop ena during ADL: transaction still acks.
